// File: rtl/exchange_cancel_accumulator_pkg.sv
// exchange_cancel_accumulator_pkg: shared types for the cancel accumulator slice
package cache_def;

    localparam int CD_AW = 5;
    localparam int CD_DW = 16;

    typedef logic [CD_AW-1:0] client_id_t;
    typedef logic [CD_DW-1:0] amount_t;

    typedef struct packed {
        client_id_t client_id;
        amount_t    amount;
    } cancel_req_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RD    = 2'd2,
        WR    = 2'd3
    } acc_state_e;

endpackage

// File: rtl/exchange_cancel_accumulator_fifo.sv
// cancel_fifo: small synchronous FIFO of pending cancel notifications
module cancel_fifo
    import cache_def::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  cancel_req_t                  din,
    output cancel_req_t                  dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    cancel_req_t mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic do_push;
    logic do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    // storage array, written at the tail pointer
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers and occupancy; reset drops everything queued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(do_push);
            rp    <= rp + PW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/exchange_cancel_accumulator.sv
// exchange_cancel_accumulator: buffers cancel notifications and accumulates saturating per-client totals
module exchange_cancel_accumulator
    import cache_def::*;
#(
    parameter int DEPTH    = 4,
    parameter int NCLIENTS = 32,
    parameter int AW       = 5,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          HRESETn,
    input  logic          exchange_go,
    input  logic [AW-1:0] exchange_client_id,
    input  logic [DW-1:0] exchange_amount,
    output logic          exchange_ready,
    input  logic [AW-1:0] rd_client_id,
    output logic [DW-1:0] cancelled_orders,
    output logic          busy,
    output logic          sat_flag,
    output logic [7:0]    drop_count
);

    localparam int CW = $clog2(DEPTH+1);

    acc_state_e    state;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] table_mem [NCLIENTS];
    logic [DW-1:0] rd_data;
    logic [DW:0]   sum;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    cancel_req_t   req;
    cancel_req_t   head;

    assign req            = '{client_id: exchange_client_id, amount: exchange_amount};
    assign exchange_ready = state != CLEAR && !full;
    assign push           = exchange_go && exchange_ready;
    assign pop            = state == WR;
    assign busy           = !empty || state != IDLE;

    cancel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (HRESETn),
        .push  (push),
        .pop   (pop),
        .din   (req),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // single table write port shared by the clear sweep and the update path
    always_comb begin
        sum   = {1'b0, head.amount} + {1'b0, rd_data};
        we    = HRESETn && (state == CLEAR || state == WR);
        waddr = state == CLEAR ? clr_addr : head.client_id;
        wdata = state == CLEAR ? '0 : (sum[DW] ? '1 : sum[DW-1:0]);
    end

    // sequencing: clear sweep, then read-modify-write of each queued notification
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == AW'(NCLIENTS-1)) state <= IDLE;
                end
                IDLE:    state <= empty ? IDLE : RD;
                RD:      state <= WR;
                WR:      state <= (count > CW'(1) || push) ? RD : IDLE;
                default: state <= CLEAR;
            endcase
        end
    end

    // sticky saturation flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            sat_flag   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (state == WR && sum[DW]) sat_flag <= 1'b1;
            if (exchange_go && !exchange_ready && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end

    // table storage write port
    always_ff @(posedge clk) begin
        if (we) table_mem[waddr] <= wdata;
    end

    // update-path read: head is stable through RD, data consumed in WR
    always_ff @(posedge clk) begin
        rd_data <= table_mem[head.client_id];
    end

    // query port with write bypass so a same-edge update is never missed
    always_ff @(posedge clk) begin
        if (!HRESETn) cancelled_orders <= '0;
        else cancelled_orders <= (we && waddr == rd_client_id) ? wdata : table_mem[rd_client_id];
    end

endmodule

// File: tb/tb_exchange_cancel_accumulator.sv
// tb_exchange_cancel_accumulator: directed plus randomized checks against a saturating-total model
module tb_exchange_cancel_accumulator;

    logic        clk = 1'b0;
    logic        HRESETn = 1'b0;
    logic        exchange_go = 1'b0;
    logic [4:0]  exchange_client_id = '0;
    logic [15:0] exchange_amount = '0;
    logic        exchange_ready;
    logic [4:0]  rd_client_id = '0;
    logic [15:0] cancelled_orders;
    logic        busy;
    logic        sat_flag;
    logic [7:0]  drop_count;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int unsigned model [32];
    bit exp_sat = 0;
    int exp_drop = 0;

    exchange_cancel_accumulator dut (
        .clk                (clk),
        .HRESETn            (HRESETn),
        .exchange_go        (exchange_go),
        .exchange_client_id (exchange_client_id),
        .exchange_amount    (exchange_amount),
        .exchange_ready     (exchange_ready),
        .rd_client_id       (rd_client_id),
        .cancelled_orders   (cancelled_orders),
        .busy               (busy),
        .sat_flag           (sat_flag),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_add(input int id, input int unsigned amt);
        int unsigned s;
        s = model[id] + amt;
        if (s > 32'hFFFF) begin
            model[id] = 32'hFFFF;
            exp_sat = 1;
        end else model[id] = s;
    endfunction

    function automatic void model_clear();
        foreach (model[i]) model[i] = 0;
        exp_sat = 0;
        exp_drop = 0;
    endfunction

    // one cycle of go with given payload; returns whether it was accepted
    task automatic drive(input int id, input int unsigned amt, output bit acc);
        exchange_go = 1'b1;
        exchange_client_id = 5'(id);
        exchange_amount = 16'(amt);
        acc = exchange_ready;
        if (acc) model_add(id, amt);
        else if (exp_drop < 255) exp_drop++;
        tick;
    endtask

    task automatic push_one(input int id, input int unsigned amt);
        bit acc = 0;
        for (int i = 0; i < 50 && !acc; i++) drive(id, amt, acc);
        exchange_go = 1'b0;
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic drain;
        int n = 0;
        while (busy && n < 200) begin
            tick;
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_client_id = 5'(i);
            tick;
            check($sformatf("%s_c%0d", tag, i), cancelled_orders, model[i]);
        end
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!exchange_ready && cnt < 100) begin
            cnt++;
            tick;
        end
    endtask

    initial begin
        bit acc;
        int cnt;
        int nacc;
        // reset values and clear sweep length
        HRESETn = 1'b0;
        tick;
        tick;
        check("rst_ready", exchange_ready, 0);
        check("rst_cancelled", cancelled_orders, 0);
        check("rst_busy", busy, 1);
        check("rst_sat", sat_flag, 0);
        check("rst_drop", drop_count, 0);
        HRESETn = 1'b1;
        model_clear();
        wait_ready(cnt);
        check("clear_cycles", cnt, 32);
        check_all("init");
        // single update then a second one observed through the bypass
        rd_client_id = 5'd3;
        push_one(3, 16'h0010);
        drain;
        tick;
        check("single_first", cancelled_orders, 16'h0010);
        check("ready_before_second", exchange_ready, 1);
        drive(3, 16'h0005, acc);
        exchange_go = 1'b0;
        tick;
        tick;
        check("pre_write_old", cancelled_orders, 16'h0010);
        tick;
        check("bypass_new", cancelled_orders, 16'h0015);
        tick;
        check("table_new", cancelled_orders, model[3]);
        drain;
        // saturation, sticky afterwards
        push_one(7, 16'hFFF0);
        drain;
        check("sat_not_yet", sat_flag, 0);
        push_one(7, 16'h0020);
        drain;
        check("sat_set", sat_flag, 1);
        push_one(7, 16'h0005);
        push_one(8, 16'h0001);
        drain;
        check("sat_sticky", sat_flag, 1);
        rd_client_id = 5'd7;
        tick;
        check("sat_total", cancelled_orders, 16'hFFFF);
        // go held 10 cycles with distinct clients: FIFO fills, then paced accepts
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            drive(10 + c, $urandom_range(0, 16'h3FFF), acc);
            nacc += int'(acc);
        end
        exchange_go = 1'b0;
        drain;
        check("burst_accepts", nacc, 7);
        check("burst_drops", drop_count, 3);
        check("drop_model", drop_count, exp_drop);
        // same-client back-to-back
        for (int c = 0; c < 4; c++) drive(31, 1, acc);
        exchange_go = 1'b0;
        drain;
        rd_client_id = 5'd31;
        tick;
        check("same_client_total", cancelled_orders, 4);
        // randomized traffic, amounts sometimes large enough to saturate
        for (int k = 0; k < 24; k++) begin
            push_one($urandom_range(0, 31), ($urandom_range(0, 3) == 0) ? $urandom_range(16'h8000, 16'hFFFF) : $urandom_range(0, 16'h00FF));
            if ($urandom_range(0, 1) == 1) tick;
        end
        drain;
        check("rand_sat", sat_flag, exp_sat);
        check("rand_drop", drop_count, exp_drop);
        check_all("rand");
        // reset with three updates queued: nothing may land
        for (int c = 0; c < 3; c++) drive((c == 2) ? 4 : c + 1, 16'h0100, acc);
        exchange_go = 1'b0;
        HRESETn = 1'b0;
        tick;
        check("mid_rst_ready", exchange_ready, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_drop", drop_count, 0);
        HRESETn = 1'b1;
        model_clear();
        wait_ready(cnt);
        check("mid_clear_cycles", cnt, 32);
        drain;
        check("mid_sat", sat_flag, 0);
        check("mid_drop", drop_count, 0);
        check_all("after_rst");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exchange_cancel_accumulator.md
# exchange_cancel_accumulator

Ingress stage ahead of the downstream cancelled-orders store: accepts exchange cancel/fill notifications (client id, amount), buffers them in a small FIFO, and applies each one as a saturating read-modify-write onto a per-client 16-bit cancelled-total table. A registered read port serves the upstream risk check with `cancelled_orders` for any client, with write-bypass so the upstream path never sees a stale total. After every reset it sweeps the table to zero.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `NCLIENTS`, 32, table entries (= 2^`AW`)
- `AW`, 5, client id width
- `DW`, 16, amount/total width
- `clk`  in  1  single clock, all logic on rising edge
- `HRESETn`  in  1  reset: one clock; reset is synchronous and active-low
- `exchange_go`  in  1  notification valid
- `exchange_client_id`  in  `AW`  client of notification
- `exchange_amount`  in  `DW`  amount cancelled
- `exchange_ready`  out  1  notification accepted this cycle when high with `exchange_go`
- `rd_client_id`  in  `AW`  client queried by upstream risk check (sampled every cycle)
- `cancelled_orders`  out  `DW`  registered total for `rd_client_id`
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `sat_flag`  out  1  sticky: some total clamped at all-ones
- `drop_count`  out  8  saturating count of `exchange_go` while `exchange_ready` low

## Operation
- FSM states: CLEAR, IDLE, RD, WR.
- CLEAR: entered on reset; writes 0 to address 0..`NCLIENTS`-1, one per cycle; after address `NCLIENTS`-1 goes to IDLE. `exchange_ready` low throughout.
- IDLE: FIFO non-empty → RD; else stay.
- RD: presents head client id to table read port (synchronous read, data next cycle) → WR.
- WR: sum = head amount + read data, computed at `DW`+1 bits; carry → write all-ones, set `sat_flag`; else write sum. Pop FIFO. → RD if FIFO still holds another entry after pop, else IDLE.
- Amount 0 is processed normally (write of unchanged value).
- `exchange_ready` = FSM ≠ CLEAR and FIFO not full. Push and pop in the same cycle allowed; when full, ready stays low even if a pop occurs that cycle (no combinational ready-from-pop).
- Dropped notification (go & !ready): not stored, `drop_count` +1, holds at 255.
- Read port: `cancelled_orders` ← table[`rd_client_id`] each edge; if the same edge writes that address (WR or CLEAR), output the write data instead (bypass).
- Reset mid-operation (any state, FIFO contents present): FIFO emptied, pending updates discarded, `sat_flag` and `drop_count` cleared, FSM → CLEAR.

## Timing
- Reset values: `exchange_ready` 0, `cancelled_orders` 0, `busy` 1 (CLEAR counts as busy), `sat_flag` 0, `drop_count` 0.
- Table ready `NCLIENTS` cycles after `HRESETn` deasserted sampled high; `exchange_ready` rises the next cycle.
- Update latency: notification accepted at edge E0 → IDLE sees it in cycle E0..E1 → RD at E1 → WR at E2 → table written at E3. Query sampled at E3 for that client returns new value via bypass; at E4 and later from table.
- Throughput: one update per 2 cycles while FIFO non-empty (WR→RD direct).
- Back-to-back same client: RD of entry B follows WR of entry A, so the read registers after the write edge; no hazard, no forwarding needed inside the update path.

## Structure
- Shared package `cache_def`: `client_id_t` (`AW` bits), `amount_t` (`DW` bits), `cancel_req_t` struct {client_id, amount}, `acc_state_e` enum {CLEAR, IDLE, RD, WR}.
- Sub-module `cancel_fifo`: parameterised `DEPTH` synchronous FIFO of `cancel_req_t` with push/pop/full/empty/count; synchronous active-low reset empties it.
- Table: inferred simple dual-port RAM, one write port (WR/CLEAR), two sync read addresses (FSM read, `rd_client_id` query).

## Test plan
- Reset then idle: `exchange_ready` low for 32 cycles after reset release, then high; all 32 queries return 0.
- Single update: client 3, amount 0x0010, then 0x0005 → query client 3 returns 0x0015; bypass visible on the write edge.
- Saturation: client 7 gets 0xFFF0 then 0x0020 → total 0xFFFF, `sat_flag` 1 and stays 1 after further updates.
- Overflow/drop: hold `exchange_go` for 10 consecutive cycles with distinct clients → 4 accepted immediately, further accepts paced at one per 2 cycles, `drop_count` equals cycles with go & !ready; each accepted client total correct.
- Same-client burst: 4 updates of 1 to client 31 back-to-back → final total 4.
- Reset mid-stream: reset asserted with 3 entries queued → after CLEAR, all totals 0, `drop_count` 0, `sat_flag` 0, no queued update applied.
